// File: rtl/rom_frame_reader.sv
// Frame reader for a fixed-latency image ROM. Issues addresses under a credit
// limit so that every in-flight read is guaranteed a FIFO slot on return.
module rom_frame_reader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 24,
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sof,
  output logic                  m_eol
);

  localparam int NPIX       = IMG_W * IMG_H;
  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int CW         = $clog2(FIFO_DEPTH + 1);
  localparam int PW         = $clog2(FIFO_DEPTH);
  localparam int XW         = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
  localparam logic [XW-1:0]         LAST_X    = XW'(IMG_W - 1);
  localparam logic [PW-1:0]         LAST_PTR  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]           DEPTH_C   = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                  r_state;
  logic                    r_busy;
  logic                    r_done;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH-1:0]   r_addr_q;
  logic [XW-1:0]           r_x;

  logic [RD_LATENCY-1:0]   r_vld_pipe;
  logic [RD_LATENCY-1:0]   r_sof_pipe;
  logic [RD_LATENCY-1:0]   r_eol_pipe;

  logic [DATA_WIDTH-1:0]   r_mem_d   [FIFO_DEPTH];
  logic                    r_mem_sof [FIFO_DEPTH];
  logic                    r_mem_eol [FIFO_DEPTH];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_cnt;

  logic [CW-1:0]           w_inflight;
  logic [CW:0]             w_used;
  logic                    w_issue;
  logic                    w_cap;
  logic                    w_pop;
  logic                    w_drained;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      w_inflight = w_inflight + CW'(r_vld_pipe[i]);
  end

  // Credits cover both queued words and reads still in the ROM, so a returning
  // word always has a slot even if the sink stalls indefinitely.
  assign w_used    = {1'b0, r_cnt} + {1'b0, w_inflight};
  assign w_issue   = (r_state == S_ISSUE) && (w_used < DEPTH_C);
  assign w_cap     = r_vld_pipe[RD_LATENCY-1];
  assign w_pop     = m_valid & m_ready;
  assign w_drained = (w_inflight == '0) &&
                     ((r_cnt == '0) || ((r_cnt == CW'(1)) && w_pop));

  assign rom_addr = w_issue ? r_addr : r_addr_q;
  assign busy     = r_busy;
  assign done     = r_done;
  assign m_valid  = (r_cnt != '0);
  assign m_data   = r_mem_d[r_rd_ptr];
  assign m_sof    = r_mem_sof[r_rd_ptr];
  assign m_eol    = r_mem_eol[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_addr   <= '0;
      r_addr_q <= '0;
      r_x      <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_issue) begin
        r_addr_q <= r_addr;
        if (r_addr != LAST_ADDR) r_addr <= r_addr + 1'b1;
        r_x <= (r_x == LAST_X) ? '0 : r_x + 1'b1;
      end
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_ISSUE;
          r_busy  <= 1'b1;
          r_addr  <= '0;
          r_x     <= '0;
        end
        S_ISSUE: if (w_issue && (r_addr == LAST_ADDR)) r_state <= S_DRAIN;
        // Leave on the cycle of the final pop so done lands right after it.
        S_DRAIN: if (w_drained) begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_sof_pipe <= '0;
      r_eol_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= w_issue;
      r_sof_pipe[0] <= (r_addr == '0);
      r_eol_pipe[0] <= (r_x == LAST_X);
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_sof_pipe[i] <= r_sof_pipe[i-1];
        r_eol_pipe[i] <= r_eol_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_d[i]   <= '0;
        r_mem_sof[i] <= 1'b0;
        r_mem_eol[i] <= 1'b0;
      end
    end else begin
      if (w_cap) begin
        r_mem_d[r_wr_ptr]   <= rom_rd_data;
        r_mem_sof[r_wr_ptr] <= r_sof_pipe[RD_LATENCY-1];
        r_mem_eol[r_wr_ptr] <= r_eol_pipe[RD_LATENCY-1];
        r_wr_ptr            <= f_next(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= f_next(r_rd_ptr);
      case ({w_cap, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_frame_reader.sv
// Drives two reader instances (ROM latency 1 and 2) from shared stimulus and
// checks each pixel stream against an index-counting reference model.
module tb_rom_frame_reader;

  localparam int W = 16;
  localparam int H = 8;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic m_ready;

  int n_chk  = 0;
  int n_pass = 0;
  int nf     = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int LAT = g + 1;
    logic        busy, done, m_valid, m_sof, m_eol;
    logic [15:0] rom_addr;
    logic [23:0] rom_rd_data, m_data, q1, q2;

    rom_frame_reader #(
      .ADDR_WIDTH(16), .DATA_WIDTH(24), .IMG_W(W), .IMG_H(H), .RD_LATENCY(LAT)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .rom_addr(rom_addr), .rom_rd_data(rom_rd_data), .m_data(m_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof), .m_eol(m_eol)
    );

    // ROM image holds its own address; no reset, like the real macro.
    always @(posedge clk) begin
      q1 <= 24'(rom_addr);
      q2 <= q1;
    end
    assign rom_rd_data = (LAT == 1) ? q1 : q2;

    int          exp_idx  = 0;
    int          max_addr = -1;
    int          dones    = 0;
    int          cyc      = 0;
    bit          armed    = 0;
    bit          stall    = 0;
    bit          post_rst = 0;
    bit          last_pop = 0;
    logic [23:0] pd;
    logic        ps, pe;

    always @(negedge clk) begin
      if (rst) begin
        post_rst = 1; exp_idx = 0; armed = 0; stall = 0; last_pop = 0; max_addr = -1;
      end else begin
        if (post_rst) begin
          chk("rst_valid", int'(m_valid), 0);
          chk("rst_busy",  int'(busy), 0);
          chk("rst_done",  int'(done), 0);
          chk("rst_addr",  int'(rom_addr), 0);
          chk("rst_data",  int'(m_data), 0);
          chk("rst_flags", int'({m_sof, m_eol}), 0);
          post_rst = 0;
        end
        chk("done_pulse", int'(done), int'(last_pop));
        if (last_pop) begin
          chk("busy_at_done", int'(busy), 0);
          dones++;
          last_pop = 0;
        end
        if (armed) begin
          cyc++;
          if (m_valid) begin
            chk("first_valid_lat", cyc, LAT + 1);
            armed = 0;
          end
        end
        if (stall) begin
          chk("stall_valid", int'(m_valid), 1);
          chk("stall_data",  int'(m_data), int'(pd));
          chk("stall_flags", int'({m_sof, m_eol}), int'({ps, pe}));
        end
        if (busy) begin
          if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
          chk("occupancy", int'((max_addr + 1 - exp_idx) <= LAT + 2), 1);
        end
        if (m_valid && m_ready) begin
          chk("pix_data", int'(m_data), exp_idx);
          chk("pix_sof",  int'(m_sof), int'(exp_idx == 0));
          chk("pix_eol",  int'(m_eol), int'((exp_idx % W) == W - 1));
          exp_idx++;
          if (exp_idx == N) begin
            last_pop = 1;
            exp_idx  = 0;
          end
        end
        stall = m_valid && !m_ready;
        pd = m_data; ps = m_sof; pe = m_eol;
        if (start && !busy && !done) begin
          armed = 1; cyc = -1; max_addr = -1;
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Random sink until both instances finish `target` frames; optionally
  // pulses start once while busy to confirm it is ignored.
  task automatic run(input int target, input int pct, input int restart_at);
    int k    = 0;
    bit sent = 0;
    while ((gi[0].dones < target || gi[1].dones < target) && k < 5000) begin
      @(posedge clk); #1;
      k++;
      m_ready = ($urandom_range(99) < pct);
      start   = !sent && (restart_at >= 0) && (gi[0].exp_idx >= restart_at);
      if (start) sent = 1;
    end
    start = 1'b0;
    chk("frame_timeout", int'(k < 5000), 1);
  endtask

  initial begin
    int stop_at;
    int k;
    rst = 1'b1; start = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Full frame, sink always ready.
    m_ready = 1'b1;
    pulse_start();
    nf++; run(nf, 100, -1);

    // Sink stalled right after start: only FIFO_DEPTH reads may be issued.
    m_ready = 1'b0;
    pulse_start();
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("hold_addr_l1", int'(gi[0].rom_addr), 2);
    chk("hold_addr_l2", int'(gi[1].rom_addr), 3);
    chk("hold_valid_l1", int'(gi[0].m_valid), 1);
    chk("hold_valid_l2", int'(gi[1].m_valid), 1);
    chk("hold_popped", gi[0].exp_idx + gi[1].exp_idx, 0);
    nf++; run(nf, 40, -1);

    // Random sink with an ignored start mid-frame.
    pulse_start();
    nf++; run(nf, 40, 50);

    // Abandon a frame with reset after a 5-cycle stall.
    pulse_start();
    stop_at = 60 + $urandom_range(30);
    k = 0;
    while (gi[0].exp_idx < stop_at && k < 2000) begin
      @(posedge clk); #1;
      k++;
      m_ready = ($urandom_range(99) < 40);
    end
    chk("reach_rst_point", int'(k < 2000), 1);
    m_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid_l1", int'(gi[0].m_valid), 0);
    chk("post_rst_busy_l2", int'(gi[1].busy), 0);
    m_ready = 1'b1;
    pulse_start();
    nf++; run(nf, 70, -1);

    repeat (5) @(posedge clk);
    chk("done_count_l1", gi[0].dones, nf);
    chk("done_count_l2", gi[1].dones, nf);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rom_frame_reader.md
Name: rom_frame_reader

Overview:
- Initiator side of the image ROM read interface: generates ROM addresses, tracks in-flight reads and returns pixels as a valid/ready stream with start-of-frame and end-of-line markers.
- Sits between the 24-bit image ROM (addr in, rd_data out, no enable) and the Sobel/HDMI pixel pipeline.
- Absorbs downstream backpressure even though the ROM cannot be stalled.

Parameters:
- ADDR_WIDTH, 16, ROM address width; the frame occupies addresses 0 .. IMG_W*IMG_H-1.
- DATA_WIDTH, 24, pixel width (RGB888).
- IMG_W, 256, pixels per line.
- IMG_H, 256, lines per frame; IMG_W*IMG_H must be <= 2**ADDR_WIDTH.
- RD_LATENCY, 1, ROM addr-to-data latency in clocks: 1 without output register, 2 with it. Legal values are 1 and 2.

Ports:
- clk, input, 1, single clock for all logic.
- rst, input, 1, reset: synchronous, active-high.
- start, input, 1, single-cycle pulse that begins one frame read.
- busy, output, 1, high from the cycle after an accepted start until done.
- done, output, 1, one-cycle pulse after the last pixel is accepted downstream.
- rom_addr, output, ADDR_WIDTH, ROM address.
- rom_rd_data, input, DATA_WIDTH, ROM read data.
- m_data, output, DATA_WIDTH, pixel.
- m_valid, output, 1, pixel valid.
- m_ready, input, 1, downstream accept.
- m_sof, output, 1, qualifies the pixel at address 0.
- m_eol, output, 1, qualifies the last pixel of each line (x == IMG_W-1).

Behaviour:
- Reset (synchronous, rst=1 at posedge): busy=0, done=0, rom_addr=0, m_valid=0, m_data=0, m_sof=0, m_eol=0. The FSM goes to IDLE. The in-flight tag pipeline and output FIFO are flushed. Reset mid-frame abandons the frame; no stale pixels appear afterwards.
- FSM states:
  - IDLE: start -> ISSUE.
  - ISSUE: when issue_addr == IMG_W*IMG_H-1 is issued -> DRAIN.
  - DRAIN: when in-flight count is 0 and the FIFO is empty -> DONE.
  - DONE: 1 cycle, done=1 -> IDLE.
- start is ignored outside IDLE.
- Issue rule: a read is issued in a cycle when state==ISSUE and fifo_count + inflight_count < FIFO_DEPTH, where FIFO_DEPTH = RD_LATENCY+2.
  - On issue, rom_addr is presented that cycle.
  - A valid tag carrying sof/eol flags enters a RD_LATENCY-stage shift pipeline.
  - The address counter increments.
- Capture rule: when the tag exits the pipeline (RD_LATENCY cycles after issue), rom_rd_data plus its flags are written into the FIFO. A captured word is never dropped. The credit check guarantees space.
- rom_addr holds its last value while not issuing. The ROM reads continuously, but untagged data is discarded.
- Output:
  - m_valid = FIFO not empty.
  - m_data/m_sof/m_eol come from the FIFO head (first-word fall-through).
  - Pop on m_valid & m_ready.
  - Simultaneous capture and pop in the same cycle is legal; the count is unchanged.
  - While m_valid=1 and m_ready=0, m_data/m_sof/m_eol are stable.
- Throughput: with m_ready held at 1, the stream carries one pixel per clock after an initial latency.
  - First m_valid is RD_LATENCY+1 cycles after the start cycle: 1 cycle to ISSUE, plus RD_LATENCY.
- Address arithmetic: the counter spans 0..IMG_W*IMG_H-1 and never wraps within a frame. The x counter wraps at IMG_W-1 and sets eol.
- done is asserted the cycle after the pop of the final pixel. busy deasserts in that same cycle.

Test Plan:
- Full frame, m_ready=1, RD_LATENCY=1, ROM loaded with data = address: start -> 65536 pixels, m_data 0..65535 in order; first m_valid 2 clocks after start; m_sof only on pixel 0; m_eol on pixels 255, 511, …, 65535 (256 pulses); done one cycle after the last pop.
- Random m_ready, ~40% duty: same ordered sequence, no gaps in data values, no duplicates; FIFO occupancy never exceeds 3; m_data stable while stalled.
- RD_LATENCY=2 with the ROM output register enabled: same full-frame check; first m_valid 3 clocks after start; FIFO occupancy never exceeds 4.
- start pulsed again at pixel 1000 while busy: ignored; exactly 65536 pixels and one done pulse.
- rst asserted at pixel 30000 with m_ready=0 for 5 cycles beforehand: next cycle m_valid=0 and busy=0; a new start gives m_data=0 with m_sof=1 as its first pixel.
- m_ready held 0 for 100 cycles right after start: exactly FIFO_DEPTH words are captured and rom_addr stays at FIFO_DEPTH-1; on release, data resumes at 0 with no loss.
